// File: rtl/imem_stream_loader.sv
// Byte-organised instruction RAM with a PC word-read port and a byte-stream load port.
// Streamed bytes are assembled into words and committed to an auto-incrementing address.
module imem_stream_loader #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int ADDR_WIDTH   = 32,
  parameter  int BYTE_WIDTH   = 8,
  parameter  int MEM_DEPTH    = 1024,
  parameter  bit BIG_ENDIAN   = 1'b1,
  parameter  int READ_LATENCY = 0,
  localparam int BPW          = DATA_WIDTH / BYTE_WIDTH,
  localparam int IDX_W        = $clog2(MEM_DEPTH),
  localparam int OFS_W        = $clog2(BPW),
  localparam int WC_W         = IDX_W - OFS_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_oob,
  output logic                  rd_misalign,
  input  logic                  ld_start,
  input  logic                  ld_stop,
  input  logic [IDX_W-1:0]      ld_base,
  input  logic [BYTE_WIDTH-1:0] ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  word_done,
  output logic [WC_W-1:0]       word_count,
  output logic                  load_active,
  output logic                  mem_full,
  output logic                  partial_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, FULL} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [OFS_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [WC_W-1:0]       word_count_q, word_count_d;
  logic                  word_done_q, word_done_d;
  logic                  partial_err_q, partial_err_d;
  logic                  mem_we;

  // Contents survive reset; only the power-on image is zero.
  logic [BYTE_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  logic base_unused;
  assign base_unused = ^ld_base[OFS_W-1:0];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    word_count_d  = word_count_q;
    word_done_d   = 1'b0;
    partial_err_d = partial_err_q;
    mem_we        = 1'b0;
    case (state_q)
      IDLE: ;
      COLLECT: begin
        if (!ld_start && ld_stop) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          if (byte_cnt_q != '0) partial_err_d = 1'b1;
        end else if (!ld_start && ld_valid) begin
          asm_d[int'(byte_cnt_q)*BYTE_WIDTH +: BYTE_WIDTH] = ld_data;
          if (byte_cnt_q == OFS_W'(BPW-1)) state_d = COMMIT;
          else byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        mem_we       = 1'b1;
        word_done_d  = 1'b1;
        word_count_d = word_count_q + 1'b1;
        byte_cnt_d   = '0;
        if (ld_stop) begin
          state_d = IDLE;
        end else if (ptr_q == IDX_W'(MEM_DEPTH-BPW)) begin
          state_d = FULL;
        end else begin
          ptr_d   = ptr_q + IDX_W'(BPW);
          state_d = COLLECT;
        end
      end
      FULL: if (ld_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Restart overrides everything except the pending commit write above.
    if (ld_start) begin
      state_d       = COLLECT;
      ptr_d         = {ld_base[IDX_W-1:OFS_W], {OFS_W{1'b0}}};
      byte_cnt_d    = '0;
      word_count_d  = '0;
      partial_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      word_count_q  <= '0;
      word_done_q   <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      word_count_q  <= word_count_d;
      word_done_q   <= word_done_d;
      partial_err_q <= partial_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BPW; i++) begin
        mem[ptr_q + IDX_W'(i)] <= asm_q[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign ld_ready    = (state_q == COLLECT);
  assign load_active = (state_q == COLLECT) || (state_q == COMMIT);
  assign mem_full    = (state_q == FULL);
  assign word_done   = word_done_q;
  assign word_count  = word_count_q;
  assign partial_err = partial_err_q;

  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_d;
  logic                  rd_oob_d, rd_misalign_d;

  assign rd_idx        = {a[IDX_W-1:OFS_W], {OFS_W{1'b0}}};
  assign rd_oob_d      = ({1'b0, a} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign rd_misalign_d = |a[OFS_W-1:0];

  // Memory holds stream order; endianness is only a read-side byte mapping.
  always_comb begin
    rd_d = '0;
    if (!rd_oob_d) begin
      for (int i = 0; i < BPW; i++) begin
        if (BIG_ENDIAN) rd_d[(BPW-1-i)*BYTE_WIDTH +: BYTE_WIDTH] = mem[rd_idx + IDX_W'(i)];
        else            rd_d[i*BYTE_WIDTH +: BYTE_WIDTH]         = mem[rd_idx + IDX_W'(i)];
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      assign rd          = rd_d;
      assign rd_oob      = rd_oob_d;
      assign rd_misalign = rd_misalign_d;
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_q;
      logic                  rd_oob_q, rd_misalign_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q          <= '0;
          rd_oob_q      <= 1'b0;
          rd_misalign_q <= 1'b0;
        end else begin
          rd_q          <= rd_d;
          rd_oob_q      <= rd_oob_d;
          rd_misalign_q <= rd_misalign_d;
        end
      end
      assign rd          = rd_q;
      assign rd_oob      = rd_oob_q;
      assign rd_misalign = rd_misalign_q;
    end
  endgenerate

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised successor to the instruction memory: a byte-organised instruction RAM with a word read port for the PC and a byte-stream load port for the UART receive FIFO.
- An internal FSM assembles incoming bytes into words and commits each word to an auto-incrementing address.
- Adds selectable endianness, optional registered read, full/overflow handling, partial-word detection, and out-of-range/misalignment flags on the read port.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 32, PC width.
- BYTE_WIDTH, 8, memory cell and load-stream width.
- MEM_DEPTH, 1024, memory size in bytes; power of 2 and a multiple of BPW.
- BIG_ENDIAN, 1, 1 = first streamed byte goes to the lowest address and the MSB; 0 = little-endian.
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- Derived: BPW = DATA_WIDTH/BYTE_WIDTH; IDX_W = $clog2(MEM_DEPTH); OFS_W = $clog2(BPW).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  ADDR_WIDTH  PC byte address.
- rd  out  DATA_WIDTH  instruction word.
- rd_oob  out  1  a >= MEM_DEPTH; same timing as rd.
- rd_misalign  out  1  a[OFS_W-1:0] != 0; same timing as rd.
- ld_start  in  1  start or restart a load at ld_base.
- ld_stop  in  1  end the load.
- ld_base  in  IDX_W  load start byte address.
- ld_data  in  BYTE_WIDTH  stream byte.
- ld_valid  in  1  ld_data valid.
- ld_ready  out  1  byte accepted when ld_valid && ld_ready.
- word_done  out  1  one-cycle pulse per committed word.
- word_count  out  IDX_W-OFS_W+1  words committed since the last start.
- load_active  out  1  FSM in COLLECT or COMMIT.
- mem_full  out  1  load reached the top of memory.
- partial_err  out  1  sticky; ld_stop arrived with a partial word held.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; write pointer, byte counter, assembly register and word_count = 0.
  - ld_ready, word_done, load_active, mem_full, partial_err = 0.
  - Registered rd/rd_oob/rd_misalign = 0.
  - Memory contents are not reset; they are zero-initialised at time 0 only.
  - Reset mid-load abandons the partial word; words already committed stay in memory.
- FSM states IDLE, COLLECT, COMMIT, FULL.
- IDLE:
  - ld_ready=0.
  - On ld_start: ptr = ld_base with the low OFS_W bits forced to 0; byte_cnt=0; word_count=0; partial_err=0; go to COLLECT.
- COLLECT:
  - ld_ready=1.
  - Each accepted byte is stored in the assembly slot byte_cnt, then byte_cnt increments.
  - On acceptance of byte BPW-1, go to COMMIT.
- COMMIT (1 cycle):
  - ld_ready=0.
  - On the clock edge leaving COMMIT, write all BPW bytes to mem[ptr..ptr+BPW-1] in stream order (ascending addresses); the endianness mapping is applied on read.
  - Same edge: word_done=1 for this cycle; word_count++; byte_cnt=0.
  - If ptr+BPW == MEM_DEPTH, go to FULL; otherwise ptr += BPW and go to COLLECT.
- FULL:
  - ld_ready=0; mem_full=1.
  - ld_stop goes to IDLE with mem_full cleared; ld_start restarts as from IDLE.
- ld_stop in COLLECT:
  - Go to IDLE.
  - If byte_cnt != 0, set partial_err; the held bytes are discarded, never written.
- ld_stop in COMMIT: the commit completes, then go to IDLE.
- ld_start in COLLECT/COMMIT/FULL restarts immediately. A pending COMMIT is still written first.
- ld_start and ld_stop in the same cycle: ld_start wins.
- A byte presented while ld_ready=0 is not consumed; the source holds it.
- Read address and data mapping:
  - idx = a[IDX_W-1:OFS_W]*BPW.
  - BIG_ENDIAN=1: rd = {mem[idx], mem[idx+1], ..., mem[idx+BPW-1]}.
  - BIG_ENDIAN=0: byte order reversed, so mem[idx] is the LSB.
  - Misaligned address: the low bits are ignored; rd_misalign=1.
  - a >= MEM_DEPTH: rd = 0; rd_oob=1.
- Read timing:
  - READ_LATENCY=0: rd is combinational; a committed word is visible the cycle after the commit edge.
  - READ_LATENCY=1: rd registers on posedge clk. Read-before-write: a read on the commit edge returns the old word.

Test Plan:
- Reset then ld_start, ld_base=0, stream 0x13,0x05,0x10,0x00 (BIG_ENDIAN=1) -> word_done pulses once, word_count=1; a=0 gives rd=0x13051000.
- Same stream with BIG_ENDIAN=0 -> a=0 gives rd=0x00100513.
- ld_base=0x3F6 (aligned to 0x3F4), MEM_DEPTH=1024, stream 12 bytes -> words at 0x3F4/0x3F8/0x3FC; after the 3rd commit mem_full=1 and ld_ready=0; 13th byte is held unaccepted; ld_stop clears mem_full.
- 6 bytes then ld_stop -> word_count=1, partial_err=1; bytes 5-6 are not in memory (a=4 reads prior contents).
- a=0x400 -> rd=0, rd_oob=1; a=0x6 -> reads word 4, rd_misalign=1; READ_LATENCY=1 -> all read results appear one cycle later.
- rst_n low during COLLECT with 2 bytes held -> all flags 0 and FSM in IDLE immediately (async); previously committed words remain readable.
